// File: rtl/dht_pkg.sv
// Shared types and frame layout for the DHT11-style sensor controller.
package dht_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RELEASE,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_CHECK
    } dht_state_t;

    localparam int unsigned FRAME_W = 40;
    localparam int unsigned US_W    = 16;

    // Byte positions in the shift register; the first byte received lands in the top slice.
    localparam int unsigned B0_LSB = 32;
    localparam int unsigned B1_LSB = 24;
    localparam int unsigned B2_LSB = 16;
    localparam int unsigned B3_LSB = 8;
    localparam int unsigned B4_LSB = 0;

    function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] f, input int unsigned lsb);
        return f[lsb +: 8];
    endfunction

    function automatic logic checksum_ok(input logic [FRAME_W-1:0] f);
        logic [7:0] w_sum;
        w_sum = frame_byte(f, B0_LSB) + frame_byte(f, B1_LSB)
              + frame_byte(f, B2_LSB) + frame_byte(f, B3_LSB);
        return w_sum == frame_byte(f, B4_LSB);
    endfunction

endpackage

// File: rtl/dht_sync_edge.sv
// Two-flop synchronizer with single-cycle rise/fall pulses taken from the synchronized level.
module dht_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/dht_controller.sv
// Host-side DHT11 controller: start pulse, response/bit timing, checksum and result registers.
module dht_controller
    import dht_pkg::*;
#(
    parameter int unsigned CLK_PER_US    = 100,
    parameter int unsigned START_LOW_US  = 18000,
    parameter int unsigned TIMEOUT_US    = 200,
    parameter int unsigned BIT_THRESH_US = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       signal,
    input  logic       en_set,
    inout  wire        data,
    output logic [7:0] hum_int,
    output logic [7:0] hum_dec,
    output logic [7:0] tmp_int,
    output logic [7:0] tmp_dec,
    output logic       valid,
    output logic       busy,
    output logic       err
);

    localparam int unsigned TICK_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US + 1) : 1;
    localparam logic [TICK_W-1:0] LP_TICK_MAX = TICK_W'(CLK_PER_US - 1);
    localparam logic [US_W-1:0]   LP_START    = US_W'(START_LOW_US);
    localparam logic [US_W-1:0]   LP_TIMEOUT  = US_W'(TIMEOUT_US);
    localparam logic [US_W-1:0]   LP_THRESH   = US_W'(BIT_THRESH_US);
    localparam logic [5:0]        LP_LAST_BIT = 6'(FRAME_W - 1);

    dht_state_t r_state;
    dht_state_t w_next_state;

    logic [TICK_W-1:0]  r_tick_cnt;
    logic [US_W-1:0]    r_us_cnt;
    logic [FRAME_W-1:0] r_shift;
    logic [5:0]         r_bit_idx;
    logic [7:0]         r_hum_int, r_hum_dec, r_tmp_int, r_tmp_dec;
    logic               r_valid, r_err;

    logic w_tick, w_sig_rise, w_dat_rise, w_dat_fall;
    logic w_timeout, w_in_wait, w_bit;
    logic w_clr_flags, w_set_valid, w_set_err, w_shift;
    logic [US_W-1:0] w_us_elapsed;

    dht_sync_edge #(.RST_VAL(1'b0)) u_sync_signal (
        .clk     (clk),
        .rst     (rst),
        .i_async (signal),
        .o_rise  (w_sig_rise),
        .o_fall  ()
    );

    dht_sync_edge #(.RST_VAL(1'b1)) u_sync_data (
        .clk     (clk),
        .rst     (rst),
        .i_async (data),
        .o_rise  (w_dat_rise),
        .o_fall  (w_dat_fall)
    );

    assign data = (r_state == ST_START && !en_set) ? 1'b0 : 1'bz;

    assign w_tick       = (r_tick_cnt == LP_TICK_MAX);
    assign w_timeout    = (r_us_cnt == LP_TIMEOUT);
    // Pulse width counts the current cycle's tick too, so an N-us pulse measures exactly N.
    assign w_us_elapsed = r_us_cnt + {{(US_W-1){1'b0}}, w_tick};
    assign w_bit        = (w_us_elapsed > LP_THRESH);
    assign w_in_wait    = (r_state inside {ST_RELEASE, ST_RESP_LOW, ST_RESP_HIGH,
                                           ST_BIT_LOW, ST_BIT_HIGH});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_clr_flags  = 1'b0;
        w_set_valid  = 1'b0;
        w_set_err    = 1'b0;
        w_shift      = 1'b0;
        unique case (r_state)
            ST_IDLE:      if (w_sig_rise) begin
                              w_next_state = ST_START;
                              w_clr_flags  = 1'b1;
                          end
            ST_START:     if (r_us_cnt == LP_START) w_next_state = ST_RELEASE;
            ST_RELEASE:   if (w_dat_fall) w_next_state = ST_RESP_LOW;
            ST_RESP_LOW:  if (w_dat_rise) w_next_state = ST_RESP_HIGH;
            ST_RESP_HIGH: if (w_dat_fall) w_next_state = ST_BIT_LOW;
            ST_BIT_LOW:   if (w_dat_rise) w_next_state = ST_BIT_HIGH;
            ST_BIT_HIGH:  if (w_dat_fall) begin
                              w_shift      = 1'b1;
                              w_next_state = (r_bit_idx == LP_LAST_BIT) ? ST_CHECK : ST_BIT_LOW;
                          end
            ST_CHECK:     begin
                              w_next_state = ST_IDLE;
                              if (checksum_ok(r_shift)) w_set_valid = 1'b1;
                              else                      w_set_err   = 1'b1;
                          end
            default:      w_next_state = ST_IDLE;
        endcase
        if (w_in_wait && w_next_state == r_state && w_timeout) begin
            w_next_state = ST_IDLE;
            w_set_err    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_us_cnt   <= '0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            if (w_next_state != r_state) r_us_cnt <= '0;
            else if (w_tick)             r_us_cnt <= r_us_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_hum_int <= '0;
            r_hum_dec <= '0;
            r_tmp_int <= '0;
            r_tmp_dec <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_shift) r_shift <= {r_shift[FRAME_W-2:0], w_bit};
            if (r_state == ST_RESP_HIGH) r_bit_idx <= '0;
            else if (w_shift)            r_bit_idx <= r_bit_idx + 1'b1;
            if (w_clr_flags) begin
                r_valid <= 1'b0;
                r_err   <= 1'b0;
            end
            if (w_set_err) r_err <= 1'b1;
            if (w_set_valid) begin
                r_valid   <= 1'b1;
                r_hum_int <= frame_byte(r_shift, B0_LSB);
                r_hum_dec <= frame_byte(r_shift, B1_LSB);
                r_tmp_int <= frame_byte(r_shift, B2_LSB);
                r_tmp_dec <= frame_byte(r_shift, B3_LSB);
            end
        end
    end

    assign hum_int = r_hum_int;
    assign hum_dec = r_hum_dec;
    assign tmp_int = r_tmp_int;
    assign tmp_dec = r_tmp_dec;
    assign valid   = r_valid;
    assign err     = r_err;
    assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dht_controller.sv
// Self-checking bench for dht_controller: hand sequences for reset/start/timeout, table-driven sensor frames.
module tb_dht_controller;

    localparam int CPU  = 2;
    localparam int SLOW = 20;
    localparam int TMO  = 40;
    localparam int THR  = 5;

    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] hd;
        logic [7:0] ti;
        logic [7:0] td;
        logic       v;
        logic       e;
    } exp_t;

    typedef struct packed {
        logic [39:0] frame;
        logic [7:0]  hi0;
        logic [7:0]  hi1;
        exp_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst, signal, en_set, r_sens_low;
    tri1  w_data;
    logic [7:0] hum_int, hum_dec, tmp_int, tmp_dec;
    logic valid, busy, err;

    int n_vec = 0;
    int n_err = 0;

    exp_t q_exp[$];
    vec_t vecs[6];

    assign w_data = (r_sens_low && en_set) ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    dht_controller #(
        .CLK_PER_US   (CPU),
        .START_LOW_US (SLOW),
        .TIMEOUT_US   (TMO),
        .BIT_THRESH_US(THR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .signal  (signal),
        .en_set  (en_set),
        .data    (w_data),
        .hum_int (hum_int),
        .hum_dec (hum_dec),
        .tmp_int (tmp_int),
        .tmp_dec (tmp_dec),
        .valid   (valid),
        .busy    (busy),
        .err     (err)
    );

    task automatic check(input string name, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".hum_int"}, int'(hum_int), int'(e.hi));
        check({tag, ".hum_dec"}, int'(hum_dec), int'(e.hd));
        check({tag, ".tmp_int"}, int'(tmp_int), int'(e.ti));
        check({tag, ".tmp_dec"}, int'(tmp_dec), int'(e.td));
        check({tag, ".valid"},   int'(valid),   int'(e.v));
        check({tag, ".err"},     int'(err),     int'(e.e));
    endtask

    task automatic hold(input logic low, input int us);
        r_sens_low = low;
        repeat (us * CPU) @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [39:0] f, input int h0, input int h1,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d,
                                input logic v, input logic e);
        vec_t r;
        r.frame = f;
        r.hi0   = 8'(h0);
        r.hi1   = 8'(h1);
        r.exp   = '{hi: a, hd: b, ti: c, td: d, v: v, e: e};
        return r;
    endfunction

    initial begin
        int cnt;
        exp_t e_rst;
        exp_t e_got;
        e_rst = '{hi: 8'd0, hd: 8'd0, ti: 8'd0, td: 8'd0, v: 1'b0, e: 1'b0};

        vecs[0] = mk(40'h23_00_18_00_3B, 2, 8, 8'd35,  8'd0,   8'd24,  8'd0,   1'b1, 1'b0);
        vecs[1] = mk(40'h23_00_18_00_3C, 2, 8, 8'd35,  8'd0,   8'd24,  8'd0,   1'b0, 1'b1);
        vecs[2] = mk(40'h80_00_00_00_80, 5, 6, 8'd128, 8'd0,   8'd0,   8'd0,   1'b1, 1'b0);
        vecs[3] = mk(40'hFF_01_10_05_15, 2, 8, 8'd255, 8'd1,   8'd16,  8'd5,   1'b1, 1'b0);
        vecs[4] = mk(40'h12_34_56_78_15, 2, 8, 8'd255, 8'd1,   8'd16,  8'd5,   1'b0, 1'b1);
        vecs[5] = mk(40'h55_AA_0F_F0_FE, 5, 6, 8'h55,  8'hAA,  8'h0F,  8'hF0,  1'b1, 1'b0);

        rst = 1'b1; signal = 1'b0; en_set = 1'b0; r_sens_low = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_outputs("reset", e_rst);
        check("reset.busy", int'(busy), 0);
        check("reset.data", int'(w_data), 1);

        // Start latency, then an asynchronous reset in the middle of the pulse.
        signal = 1'b1;
        repeat (2) @(negedge clk);
        check("lat.data_2clk", int'(w_data), 1);
        @(negedge clk);
        check("lat.data_3clk", int'(w_data), 0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst.data", int'(w_data), 1);
        check("midrst.busy", int'(busy), 0);
        check_outputs("midrst", e_rst);
        @(negedge clk);
        rst = 1'b0;
        signal = 1'b0;
        repeat (4) @(negedge clk);

        // Full start pulse with a second edge during START, then no response.
        signal = 1'b1;
        cnt = 0;
        while (w_data !== 1'b0 && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("pulse.latency", cnt, 3);
        cnt = 0;
        while (w_data === 1'b0 && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (cnt == 20) signal = 1'b0;
            if (cnt == 24) signal = 1'b1;
        end
        check_range("pulse.low_clks", cnt, 2 * SLOW, 2 * SLOW + 1);
        cnt = 0;
        while (err !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check_range("noresp.err_clks", cnt, 2 * TMO, 2 * TMO + 1);
        check("noresp.busy", int'(busy), 0);
        check_outputs("noresp", '{hi: 8'd0, hd: 8'd0, ti: 8'd0, td: 8'd0, v: 1'b0, e: 1'b1});
        repeat (20) @(negedge clk);
        check("noresp.stays_idle", int'(busy), 0);
        signal = 1'b0;

        // Sensor frames: the sensor owns the line, so the host pulse is suppressed.
        en_set = 1'b1;
        for (int v = 0; v < 6; v++) begin
            q_exp.push_back(vecs[v].exp);
            repeat (4) @(negedge clk);
            signal = 1'b1;
            cnt = 0;
            while (busy !== 1'b1 && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            check_range($sformatf("v%0d.busy_rise", v), cnt, 0, 19);
            check($sformatf("v%0d.no_drive", v), int'(w_data), 1);
            repeat (50) @(negedge clk);
            hold(1'b1, 10);
            hold(1'b0, 10);
            for (int i = 39; i >= 0; i--) begin
                hold(1'b1, 5);
                hold(1'b0, vecs[v].frame[i] ? int'(vecs[v].hi1) : int'(vecs[v].hi0));
            end
            hold(1'b1, 5);
            r_sens_low = 1'b0;
            cnt = 0;
            while (busy !== 1'b0 && cnt < 100) begin
                @(negedge clk);
                cnt++;
            end
            check_range($sformatf("v%0d.done", v), cnt, 0, 99);
            if (q_exp.size() > 0) begin
                e_got = q_exp.pop_front();
                check_outputs($sformatf("v%0d", v), e_got);
            end
            signal = 1'b0;
        end
        check("scoreboard.empty", q_exp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
